// File: rtl/data_memory_if.sv
// Request/response bundle between the CPU datapath and the data memory stage.
// Store data and address come from rs2 and alu_out; the fault record feeds trap/debug logic.
interface data_memory_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        fault_clear;
  logic [31:0] read_data;
  logic        access_fault;
  logic        fault_sticky;
  logic [31:0] fault_addr;

  modport master (
    output mem_read, mem_write, funct3, addr, write_data, fault_clear,
    input  read_data, access_fault, fault_sticky, fault_addr
  );

  modport slave (
    input  mem_read, mem_write, funct3, addr, write_data, fault_clear,
    output read_data, access_fault, fault_sticky, fault_addr
  );
endinterface

// File: rtl/data_memory.sv
// RV32I data memory: little-endian byte/half/word loads (combinational) and stores (on clk),
// with access-fault detection and a sticky first-fault record.
module data_memory #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input logic          clk,
  input logic          reset,
  data_memory_if.slave bus
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          active, legal, misaligned, out_of_range, fault, wr_en;
  logic [31:0]   word, rdata, wdata;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [3:0]    be;
  logic          sticky_q, sticky_d;
  logic [31:0]   faddr_q, faddr_d;

  always_comb begin
    idx    = bus.addr[AW+1:2];
    lane   = bus.addr[1:0];
    active = bus.mem_read | bus.mem_write;
    // A combined read+write is a store, so store legality applies.
    if (bus.mem_write) begin
      legal = bus.funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      legal = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    misaligned = 1'b0;
    case (bus.funct3[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
    out_of_range = |bus.addr[31:AW+2];
    fault        = active & (~legal | misaligned | out_of_range);
    wr_en        = bus.mem_write & ~fault;
  end

  always_comb begin
    word  = mem_q[idx];
    rbyte = word[{lane, 3'b000} +: 8];
    rhalf = lane[1] ? word[31:16] : word[15:0];
    rdata = '0;
    if (bus.mem_read && !fault) begin
      case (bus.funct3)
        3'b000:  rdata = {{24{rbyte[7]}}, rbyte};
        3'b100:  rdata = {24'h0, rbyte};
        3'b001:  rdata = {{16{rhalf[15]}}, rhalf};
        3'b101:  rdata = {16'h0, rhalf};
        3'b010:  rdata = word;
        default: rdata = '0;
      endcase
    end
  end

  // Replicate store data across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    case (bus.funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.write_data[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.write_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = bus.write_data;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // First fault wins unless a clear lands in the same cycle as a new fault.
  always_comb begin
    sticky_d = sticky_q;
    faddr_d  = faddr_q;
    if (bus.fault_clear) begin
      sticky_d = 1'b0;
      faddr_d  = '0;
    end
    if (fault && (!sticky_q || bus.fault_clear)) begin
      sticky_d = 1'b1;
      faddr_d  = bus.addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= 1'b0;
      faddr_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      faddr_q  <= faddr_d;
    end
  end

  assign bus.read_data    = rdata;
  assign bus.access_fault = fault;
  assign bus.fault_sticky = sticky_q;
  assign bus.fault_addr   = faddr_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: byte-array reference model, expected load data queued
// at drive time and popped when the combinational result is sampled.
module tb_data_memory;
  logic clk = 1'b0;
  logic reset;

  data_memory_if bus ();

  data_memory #(.DEPTH(256), .AW(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  logic [7:0]  ref_mem [1024];
  logic        ref_sticky;
  logic [31:0] ref_faddr;
  logic [31:0] rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_fault(input logic r, input logic w, input logic [2:0] f3,
                                   input logic [31:0] a);
    logic ok_f3, ok_align;
    if (!(r || w)) return 1'b0;
    if (w) ok_f3 = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else   ok_f3 = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    ok_align = 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) ok_align = 1'b0;
    if (f3 == 3'd2 && (a % 4 != 0)) ok_align = 1'b0;
    return !(ok_f3 && ok_align && (a < 32'd1024));
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    logic [9:0] p;
    p = a[9:0];
    case (f3)
      3'd0: return {{24{ref_mem[p][7]}}, ref_mem[p]};
      3'd4: return {24'h0, ref_mem[p]};
      3'd1: return {{16{ref_mem[p+1][7]}}, ref_mem[p+1], ref_mem[p]};
      3'd5: return {16'h0, ref_mem[p+1], ref_mem[p]};
      3'd2: return {ref_mem[p+3], ref_mem[p+2], ref_mem[p+1], ref_mem[p]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_idle();
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.funct3      = 3'd0;
    bus.addr        = 32'h0;
    bus.write_data  = 32'h0;
    bus.fault_clear = 1'b0;
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    ref_sticky = 1'b0;
    ref_faddr  = 32'h0;
  endtask

  // Entered just after a rising edge; returns just after the next one.
  task automatic access(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic clr, input string tag,
                        output logic [31:0] got_rd);
    logic        flt;
    logic [31:0] exp_rd;
    logic [9:0]  p;
    exp_t        e;
    bus.mem_read    = r;
    bus.mem_write   = w;
    bus.funct3      = f3;
    bus.addr        = a;
    bus.write_data  = wd;
    bus.fault_clear = clr;
    flt    = m_fault(r, w, f3, a);
    exp_rd = (r && !flt) ? m_load(f3, a) : 32'h0;
    exp_q.push_back('{tag, exp_rd});
    #4;
    e      = exp_q.pop_front();
    got_rd = bus.read_data;
    check_eq({e.tag, ".rd"}, bus.read_data, e.val);
    check_eq({tag, ".fault"}, 32'(bus.access_fault), 32'(flt));
    @(posedge clk);
    #1;
    if (w && !flt) begin
      p = a[9:0];
      case (f3)
        3'd0: ref_mem[p] = wd[7:0];
        3'd1: begin ref_mem[p] = wd[7:0]; ref_mem[p+1] = wd[15:8]; end
        default: begin
          ref_mem[p]   = wd[7:0];
          ref_mem[p+1] = wd[15:8];
          ref_mem[p+2] = wd[23:16];
          ref_mem[p+3] = wd[31:24];
        end
      endcase
    end
    if (clr && !flt) begin
      ref_sticky = 1'b0;
      ref_faddr  = 32'h0;
    end else if (flt && (clr || !ref_sticky)) begin
      ref_sticky = 1'b1;
      ref_faddr  = a;
    end
    check_eq({tag, ".sticky"}, 32'(bus.fault_sticky), 32'(ref_sticky));
    check_eq({tag, ".faddr"}, bus.fault_addr, ref_faddr);
    set_idle();
  endtask

  initial begin
    logic [2:0] f3_tab [7];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
    reset = 1'b1;
    set_idle();
    ref_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst.sticky", 32'(bus.fault_sticky), 32'h0);
    check_eq("rst.faddr", bus.fault_addr, 32'h0);

    access(1, 0, 3'd2, 32'h10, 32'h0, 0, "lw10", rd);
    check_eq("plan.lw10", rd, 32'h0);
    access(0, 1, 3'd2, 32'h20, 32'h8899_AABB, 0, "sw20", rd);
    access(0, 1, 3'd0, 32'h22, 32'h0000_00F1, 0, "sb22", rd);
    access(1, 0, 3'd2, 32'h20, 32'h0, 0, "lw20", rd);
    check_eq("plan.lw20", rd, 32'h88F1_AABB);
    access(1, 0, 3'd0, 32'h22, 32'h0, 0, "lb22", rd);
    check_eq("plan.lb22", rd, 32'hFFFF_FFF1);
    access(1, 0, 3'd4, 32'h22, 32'h0, 0, "lbu22", rd);
    check_eq("plan.lbu22", rd, 32'h0000_00F1);
    access(1, 0, 3'd1, 32'h20, 32'h0, 0, "lh20", rd);
    check_eq("plan.lh20", rd, 32'hFFFF_AABB);
    access(1, 0, 3'd5, 32'h20, 32'h0, 0, "lhu20", rd);
    check_eq("plan.lhu20", rd, 32'h0000_AABB);
    access(1, 0, 3'd1, 32'h22, 32'h0, 0, "lh22", rd);
    check_eq("plan.lh22", rd, 32'hFFFF_88F1);

    access(0, 1, 3'd2, 32'h40, 32'hCAFE_F00D, 0, "sw40", rd);
    access(0, 1, 3'd2, 32'h41, 32'h1234_5678, 0, "sw41_mis", rd);
    check_eq("plan.sticky41", 32'(bus.fault_sticky), 32'h1);
    check_eq("plan.faddr41", bus.fault_addr, 32'h41);
    access(1, 0, 3'd2, 32'h40, 32'h0, 0, "lw40", rd);
    check_eq("plan.lw40", rd, 32'hCAFE_F00D);
    access(1, 0, 3'd2, 32'h400, 32'h0, 0, "lw400_oor", rd);
    check_eq("plan.lw400", rd, 32'h0);
    check_eq("plan.faddr_hold", bus.fault_addr, 32'h41);
    access(1, 0, 3'd1, 32'h03, 32'h0, 1, "lh03_clr", rd);
    check_eq("plan.sticky03", 32'(bus.fault_sticky), 32'h1);
    check_eq("plan.faddr03", bus.fault_addr, 32'h3);
    access(0, 0, 3'd0, 32'h0, 32'h0, 1, "clr", rd);
    check_eq("plan.cleared", 32'(bus.fault_sticky), 32'h0);

    access(1, 1, 3'd2, 32'h20, 32'h0102_0304, 0, "rw20", rd);
    check_eq("plan.rw20_old", rd, 32'h88F1_AABB);
    access(1, 0, 3'd2, 32'h20, 32'h0, 0, "lw20_new", rd);
    check_eq("plan.lw20_new", rd, 32'h0102_0304);
    access(0, 1, 3'd4, 32'h30, 32'hFFFF_FFFF, 0, "sbu_illegal", rd);
    access(0, 1, 3'd1, 32'h42, 32'hAAAA_5A5A, 0, "sh42", rd);
    access(1, 0, 3'd2, 32'h40, 32'h0, 0, "lw40_sh", rd);
    check_eq("plan.lw40_sh", rd, 32'h5A5A_F00D);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1000, 1100))
                                      : 32'($urandom_range(0, 127));
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 6)],
             a, $urandom, 1'($urandom_range(0, 7) == 0), $sformatf("rnd%0d", i), rd);
    end

    // Store pending when reset rises: the edge must not write.
    bus.mem_write  = 1'b1;
    bus.funct3     = 3'd2;
    bus.addr       = 32'h10;
    bus.write_data = 32'hDEAD_BEEF;
    #2 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    set_idle();
    ref_reset();
    access(1, 0, 3'd2, 32'h10, 32'h0, 0, "lw10_after_rst", rd);
    check_eq("plan.lw10_rst", rd, 32'h0);
    check_eq("plan.sticky_rst", 32'(bus.fault_sticky), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
